// File: rtl/bus_xfer_controller.sv
// Serial system-bus transaction sequencer: latches the granted master's request, selects the slave,
// shifts address/write data out LSB first, waits for slave ready and assembles serial read data.
module bus_xfer_controller #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_SLV = 3,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         bus_grant,
    input  logic               m1_start,
    input  logic               m1_wr,
    input  logic [1:0]         m1_slave_id,
    input  logic [ADDR_W-1:0]  m1_addr,
    input  logic [DATA_W-1:0]  m1_wdata,
    input  logic               m2_start,
    input  logic               m2_wr,
    input  logic [1:0]         m2_slave_id,
    input  logic [ADDR_W-1:0]  m2_addr,
    input  logic [DATA_W-1:0]  m2_wdata,
    input  logic               slave_ready,
    input  logic               slave_rbit,
    output logic [NUM_SLV-1:0] slave_sel,
    output logic               bus_valid,
    output logic               bus_mode,
    output logic               bus_bit,
    output logic [DATA_W-1:0]  rdata,
    output logic               done,
    output logic               err,
    output logic               ctrl_busy,
    output logic               xfer_release
);

    localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned CNT_W = $clog2(MAX_W);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEL   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_WDATA = 3'd4;
    localparam logic [2:0] ST_RDATA = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;
    localparam logic [2:0] ST_ERR   = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [1:0]        id_q, id_d;
    logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
    logic [DATA_W-1:0] wdata_sh_q, wdata_sh_d;
    logic [DATA_W-2:0] rsh_q, rsh_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic              accept;
    logic              req_wr;
    logic [1:0]        req_id;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              bad_id;
    logic              grant_lost;
    logic              addr_last;
    logic              data_last;
    logic              tmr_expired;
    logic              sel_active;

    // Only the master named by the current grant may start; grant 0 and 3 accept nobody.
    always_comb begin
        accept    = 1'b0;
        req_wr    = m1_wr;
        req_id    = m1_slave_id;
        req_addr  = m1_addr;
        req_wdata = m1_wdata;
        if (bus_grant == 2'd1 && m1_start) begin
            accept = 1'b1;
        end else if (bus_grant == 2'd2 && m2_start) begin
            accept    = 1'b1;
            req_wr    = m2_wr;
            req_id    = m2_slave_id;
            req_addr  = m2_addr;
            req_wdata = m2_wdata;
        end
    end

    assign bad_id      = 32'(req_id) >= NUM_SLV;
    assign grant_lost  = bus_grant != owner_q;
    assign addr_last   = cnt_q == CNT_W'(ADDR_W - 1);
    assign data_last   = cnt_q == CNT_W'(DATA_W - 1);
    assign tmr_expired = timer_q == TMR_W'(TIMEOUT - 1);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        id_d       = id_q;
        addr_sh_d  = addr_sh_q;
        wdata_sh_d = wdata_sh_q;
        rsh_d      = rsh_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d    = bus_grant;
                    wr_d       = req_wr;
                    id_d       = req_id;
                    addr_sh_d  = req_addr;
                    wdata_sh_d = req_wdata;
                    state_d    = bad_id ? ST_ERR : ST_SEL;
                end
            end
            ST_SEL: begin
                cnt_d   = '0;
                state_d = grant_lost ? ST_ERR : ST_ADDR;
            end
            ST_ADDR: begin
                if (grant_lost) begin
                    state_d = ST_ERR;
                end else begin
                    addr_sh_d = addr_sh_q >> 1;
                    if (addr_last) begin
                        state_d = ST_WAIT;
                        timer_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            // Grant loss beats ready; ready beats the timeout in the same cycle.
            ST_WAIT: begin
                if (grant_lost) begin
                    state_d = ST_ERR;
                end else if (slave_ready) begin
                    state_d = wr_q ? ST_WDATA : ST_RDATA;
                    cnt_d   = '0;
                end else if (tmr_expired) begin
                    state_d = ST_ERR;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_WDATA: begin
                if (grant_lost) begin
                    state_d = ST_ERR;
                end else begin
                    wdata_sh_d = wdata_sh_q >> 1;
                    if (data_last) state_d = ST_DONE;
                    else           cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            // The last bit goes straight into rdata, so the shifter holds only DATA_W-1 bits.
            ST_RDATA: begin
                if (grant_lost) begin
                    state_d = ST_ERR;
                end else if (data_last) begin
                    rdata_d = {slave_rbit, rsh_q};
                    state_d = ST_DONE;
                end else begin
                    rsh_d = {slave_rbit, rsh_q[DATA_W-2:1]};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            wr_q       <= 1'b0;
            id_q       <= '0;
            addr_sh_q  <= '0;
            wdata_sh_q <= '0;
            rsh_q      <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wr_q       <= wr_d;
            id_q       <= id_d;
            addr_sh_q  <= addr_sh_d;
            wdata_sh_q <= wdata_sh_d;
            rsh_q      <= rsh_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        sel_active = (state_q == ST_SEL) || (state_q == ST_ADDR) || (state_q == ST_WAIT) ||
                     (state_q == ST_WDATA) || (state_q == ST_RDATA);
        slave_sel  = sel_active ? (NUM_SLV'(1) << id_q) : '0;
        bus_mode   = sel_active & wr_q;
        bus_valid  = (state_q == ST_ADDR) || (state_q == ST_WDATA);
        bus_bit    = 1'b0;
        if (state_q == ST_ADDR)  bus_bit = addr_sh_q[0];
        if (state_q == ST_WDATA) bus_bit = wdata_sh_q[0];
        done         = state_q == ST_DONE;
        err          = state_q == ST_ERR;
        xfer_release = done | err;
        ctrl_busy    = state_q != ST_IDLE;
        rdata        = rdata_q;
    end

endmodule

// File: tb/tb_bus_xfer_controller.sv
// Scoreboard bench for bus_xfer_controller: the driver predicts each transaction's outcome from
// its timing rules; a negedge monitor pops the prediction whenever done/err appears.
module tb_bus_xfer_controller;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int NUM_SLV = 3;
    localparam int TIMEOUT = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [1:0]         bus_grant = '0;
    logic               m1_start = 1'b0, m1_wr = 1'b0;
    logic [1:0]         m1_slave_id = '0;
    logic [ADDR_W-1:0]  m1_addr = '0;
    logic [DATA_W-1:0]  m1_wdata = '0;
    logic               m2_start = 1'b0, m2_wr = 1'b0;
    logic [1:0]         m2_slave_id = '0;
    logic [ADDR_W-1:0]  m2_addr = '0;
    logic [DATA_W-1:0]  m2_wdata = '0;
    logic               slave_ready = 1'b0, slave_rbit = 1'b0;
    logic [NUM_SLV-1:0] slave_sel;
    logic               bus_valid, bus_mode, bus_bit;
    logic [DATA_W-1:0]  rdata;
    logic               done, err, ctrl_busy, xfer_release;

    bus_xfer_controller #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NUM_SLV(NUM_SLV),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus_grant   (bus_grant),
        .m1_start    (m1_start),
        .m1_wr       (m1_wr),
        .m1_slave_id (m1_slave_id),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m2_start    (m2_start),
        .m2_wr       (m2_wr),
        .m2_slave_id (m2_slave_id),
        .m2_addr     (m2_addr),
        .m2_wdata    (m2_wdata),
        .slave_ready (slave_ready),
        .slave_rbit  (slave_rbit),
        .slave_sel   (slave_sel),
        .bus_valid   (bus_valid),
        .bus_mode    (bus_mode),
        .bus_bit     (bus_bit),
        .rdata       (rdata),
        .done        (done),
        .err         (err),
        .ctrl_busy   (ctrl_busy),
        .xfer_release(xfer_release)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        bit          wr;
        logic [7:0]  rdata;
        int          nbits;
        logic [31:0] bits;
        logic [2:0]  sel;
        int          lat;
        int          start;
    } exp_t;

    exp_t       sbq[$];
    int         errors = 0;
    int         checks = 0;
    bit         quiet  = 1'b1;
    logic [7:0] model_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: collects serial bits and select activity, compares on every done/err.
    initial begin
        logic [31:0] got_bits;
        int          nb;
        logic [2:0]  sel_or;
        bit          mode_bad;
        exp_t        e;
        got_bits = '0; nb = 0; sel_or = '0; mode_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                got_bits = '0; nb = 0; sel_or = '0; mode_bad = 1'b0;
                continue;
            end
            check("sel_onehot", 32'($countones(slave_sel) > 1), 0);
            if (bus_valid && nb < 32) begin
                got_bits[nb] = bus_bit;
                nb++;
            end
            sel_or = sel_or | slave_sel;
            if (sbq.size() > 0 && slave_sel != 0 && bus_mode !== sbq[0].wr) mode_bad = 1'b1;
            if (sbq.size() == 0 && !quiet)
                check("idle_outputs", {ctrl_busy, slave_sel, bus_valid, bus_mode, xfer_release}, 0);
            if (done || err) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_end: done=%0b err=%0b with nothing pending", done, err);
                end else begin
                    e = sbq.pop_front();
                    check("end_kind {done,err}", {done, err}, e.is_err ? 2'b01 : 2'b10);
                    check("release", xfer_release, 1);
                    check("busy_at_end", ctrl_busy, 1);
                    check("latency", cyc - e.start, e.lat);
                    check("bit_count", nb, e.nbits);
                    check("bit_stream", got_bits, e.bits);
                    check("slave_sel_seen", sel_or, e.sel);
                    check("bus_mode", mode_bad, 0);
                    check("rdata", rdata, e.rdata);
                end
                got_bits = '0; nb = 0; sel_or = '0; mode_bad = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            m1_start    = 1'b0;
            m2_start    = 1'b0;
            bus_grant   = 2'($urandom_range(0, 3));
            slave_ready = 1'($urandom_range(0, 1));
            slave_rbit  = 1'($urandom_range(0, 1));
        end
    endtask

    // One transaction from master g. d: cycles of WAIT_RDY before ready rises.
    // drop_c > 0: grant becomes drop_val from that cycle on. rst_at >= 0: reset at that cycle.
    task automatic run_txn(input int g, input logic wr, input logic [1:0] id,
                           input logic [11:0] addr, input logic [7:0] wdata, input logic [7:0] rword,
                           input int d, input int drop_c, input logic [1:0] drop_val,
                           input int rst_at);
        exp_t e;
        bit   ready_ok;
        int   nat, last_t, wait_start, rd_start;
        logic own_start;
        ready_ok   = d < TIMEOUT;
        wait_start = 2 + ADDR_W;
        rd_start   = wait_start + d + 1;
        e.wr = wr;
        if (int'(id) >= NUM_SLV) begin
            e.lat = 1; e.is_err = 1'b1;
        end else begin
            nat = ready_ok ? (rd_start + DATA_W) : (wait_start + TIMEOUT);
            if (drop_c > 0 && drop_c < nat) begin
                e.lat = drop_c + 1; e.is_err = 1'b1;
            end else begin
                e.lat = nat; e.is_err = !ready_ok;
            end
        end
        e.nbits = 0; e.bits = '0;
        if (int'(id) < NUM_SLV) begin
            for (int k = 0; k < ADDR_W; k++)
                if (2 + k < e.lat) begin e.bits[e.nbits] = addr[k]; e.nbits++; end
            if (wr && ready_ok)
                for (int k = 0; k < DATA_W; k++)
                    if (rd_start + k < e.lat) begin e.bits[e.nbits] = wdata[k]; e.nbits++; end
        end
        if (!e.is_err && !wr && rst_at < 0) model_rdata = rword;
        e.rdata = model_rdata;
        e.sel   = (int'(id) < NUM_SLV) ? (3'b001 << id) : 3'b000;
        if (rst_at >= 0) quiet = 1'b1;
        last_t = (rst_at >= 0) ? rst_at : e.lat;
        for (int t = 0; t <= last_t; t++) begin
            @(negedge clk);
            if (t == 0) begin
                e.start = cyc;
                if (rst_at < 0) sbq.push_back(e);
            end
            if (t == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_mid_outputs", {slave_sel, bus_valid, bus_mode, bus_bit, done, err,
                                          ctrl_busy, xfer_release}, 0);
                check("rst_mid_rdata", rdata, 0);
            end
            bus_grant = (drop_c > 0 && t >= drop_c) ? drop_val : 2'(g);
            own_start = (t == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
            if (g == 1) begin
                m1_start = own_start; m1_wr = wr; m1_slave_id = id; m1_addr = addr;
                m1_wdata = wdata;
                m2_start = 1'($urandom_range(0, 1)); m2_wr = 1'($urandom_range(0, 1));
                m2_slave_id = 2'($urandom); m2_addr = 12'($urandom); m2_wdata = 8'($urandom);
            end else begin
                m2_start = own_start; m2_wr = wr; m2_slave_id = id; m2_addr = addr;
                m2_wdata = wdata;
                m1_start = 1'($urandom_range(0, 1)); m1_wr = 1'($urandom_range(0, 1));
                m1_slave_id = 2'($urandom); m1_addr = 12'($urandom); m1_wdata = 8'($urandom);
            end
            if (t < wait_start) slave_ready = 1'($urandom_range(0, 1));
            else                slave_ready = t >= wait_start + d;
            if (t >= rd_start && t < rd_start + DATA_W) slave_rbit = rword[t - rd_start];
            else                                        slave_rbit = 1'($urandom_range(0, 1));
        end
        if (rst_at >= 0) begin
            model_rdata = '0;
            @(negedge clk);
            m1_start = 1'b0; m2_start = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            quiet = 1'b0;
        end
    endtask

    initial begin
        int         g, d, drop_c;
        logic       wr;
        logic [1:0] id, drop_val;
        repeat (2) @(negedge clk);
        check("reset_outputs", {slave_sel, bus_valid, bus_mode, bus_bit, done, err, ctrl_busy,
                                xfer_release}, 0);
        check("reset_rdata", rdata, 0);
        rst = 1'b0;
        @(negedge clk);
        quiet = 1'b0;

        // M1 write to slave 1, ready two cycles into WAIT_RDY.
        run_txn(1, 1'b1, 2'd1, 12'hA5C, 8'h3C, 8'h00, 2, 0, 2'd0, -1);
        // M2 read from slave 2, back-to-back.
        run_txn(2, 1'b0, 2'd2, 12'h123, 8'h00, 8'h96, 1, 0, 2'd0, -1);
        idle(1);
        // Starts from non-granted masters must be ignored.
        @(negedge clk); bus_grant = 2'd1; m1_start = 1'b0; m2_start = 1'b1;
        @(negedge clk); bus_grant = 2'd3; m1_start = 1'b1; m2_start = 1'b1;
        @(negedge clk); bus_grant = 2'd0; m1_start = 1'b1; m2_start = 1'b1;
        idle(2);
        // Timeout on a read: rdata keeps 0x96.
        run_txn(1, 1'b0, 2'd0, 12'h0F0, 8'h00, 8'h55, 6, 0, 2'd0, -1);
        // Out-of-range slave id.
        run_txn(2, 1'b1, 2'd3, 12'hFFF, 8'hFF, 8'h00, 0, 0, 2'd0, -1);
        // Grant dropped mid-ADDR.
        run_txn(1, 1'b1, 2'd2, 12'h5A5, 8'hC3, 8'h00, 0, 7, 2'd0, -1);
        idle(1);
        // Reset during WDATA: no err pulse, rdata cleared.
        run_txn(1, 1'b1, 2'd0, 12'h321, 8'hA7, 8'h00, 0, 0, 2'd0, 2 + ADDR_W + 1 + 3);

        for (int i = 0; i < 40; i++) begin
            g      = $urandom_range(1, 2);
            wr     = 1'($urandom_range(0, 1));
            id     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            d      = $urandom_range(0, 5);
            drop_c = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 28) : 0;
            case ($urandom_range(0, 2))
                0:       drop_val = 2'd0;
                1:       drop_val = 2'(3 - g);
                default: drop_val = 2'd3;
            endcase
            run_txn(g, wr, id, 12'($urandom), 8'($urandom), 8'($urandom), d, drop_c, drop_val, -1);
            idle($urandom_range(0, 2));
        end

        idle(4);
        check("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
